// File: rtl/multiplexador_pkg.sv
// multiplexador_pkg
//   Shared definitions for the 7-segment display multiplexer.
//   - Segment bit order: {g,f,e,d,c,b,a}; bit 0 = a.
//   - Active-high glyph constants for BCD 0..9, dash and blank.
//   - Special BCD codes: COD_TRACO (dash) and COD_APAGADO (blank).
//   - Scan FSM state encoding.
package multiplexador_pkg;

   localparam int unsigned SEG_LARGURA = 7;

   // Segment bit order as seen on the shared segment bus.
   typedef struct packed {
      logic g;
      logic f;
      logic e;
      logic d;
      logic c;
      logic b;
      logic a;
   } segmentos_t;

   // Active-high glyphs; the parent applies the board polarity.
   localparam logic [SEG_LARGURA-1:0] GLIFO_0       = 7'h3F;
   localparam logic [SEG_LARGURA-1:0] GLIFO_1       = 7'h06;
   localparam logic [SEG_LARGURA-1:0] GLIFO_2       = 7'h5B;
   localparam logic [SEG_LARGURA-1:0] GLIFO_3       = 7'h4F;
   localparam logic [SEG_LARGURA-1:0] GLIFO_4       = 7'h66;
   localparam logic [SEG_LARGURA-1:0] GLIFO_5       = 7'h6D;
   localparam logic [SEG_LARGURA-1:0] GLIFO_6       = 7'h7D;
   localparam logic [SEG_LARGURA-1:0] GLIFO_7       = 7'h07;
   localparam logic [SEG_LARGURA-1:0] GLIFO_8       = 7'h7F;
   localparam logic [SEG_LARGURA-1:0] GLIFO_9       = 7'h6F;
   localparam logic [SEG_LARGURA-1:0] GLIFO_TRACO   = 7'h40;
   localparam logic [SEG_LARGURA-1:0] GLIFO_APAGADO = 7'h00;

   localparam logic [3:0] COD_TRACO   = 4'hA;
   localparam logic [3:0] COD_APAGADO = 4'hF;

   // E_OCIOSO : after reset, nothing shown until the first step
   // E_PASSO  : blanking cycle right after an index advance
   // E_EXIBE  : current digit driven
   // E_PAUSA  : display disabled after having shown something
   typedef enum logic [1:0] {
      E_OCIOSO,
      E_PASSO,
      E_EXIBE,
      E_PAUSA
   } estado_t;

endpackage

// File: rtl/decodificador_7seg.sv
// decodificador_7seg
//   Purely combinational BCD nibble to active-high 7-segment glyph.
//   Codes 0..9 give digits, COD_TRACO gives a dash, everything else blank.
// Ports:
//   codigo : in  4-bit BCD/special code
//   glifo  : out 7-bit glyph {g,f,e,d,c,b,a}, active-high
module decodificador_7seg
   import multiplexador_pkg::*;
(
   input  logic [3:0]             codigo,
   output logic [SEG_LARGURA-1:0] glifo
);

   always_comb begin
      glifo = GLIFO_APAGADO;
      case (codigo)
         4'd0:      glifo = GLIFO_0;
         4'd1:      glifo = GLIFO_1;
         4'd2:      glifo = GLIFO_2;
         4'd3:      glifo = GLIFO_3;
         4'd4:      glifo = GLIFO_4;
         4'd5:      glifo = GLIFO_5;
         4'd6:      glifo = GLIFO_6;
         4'd7:      glifo = GLIFO_7;
         4'd8:      glifo = GLIFO_8;
         4'd9:      glifo = GLIFO_9;
         COD_TRACO: glifo = GLIFO_TRACO;
         default:   glifo = GLIFO_APAGADO;
      endcase
   end

endmodule

// File: rtl/multiplexador_display.sv
// multiplexador_display
//   Scans an N-digit common-anode 7-segment display. The divider's
//   multiplex output is sampled as data on clk; each rising edge advances
//   one digit. A frame snapshot of digitos/pontos is taken when the index
//   wraps to 0, so a frame never mixes old and new digits. Every index
//   change is preceded by one cycle with all anodes off (anti-ghosting).
//   All outputs are registered.
// Optional build macro:
//   SUPRIME_ZEROS_EN : leading-zero suppression at snapshot time
//                      (digit 0 is never suppressed, points untouched).
// Parameters:
//   N_DIGITOS   : digits scanned (2..8)
//   ATIVO_BAIXO : 1 = segments, point and anodes active-low
// Ports:
//   clk            : in  system clock
//   reset          : in  synchronous, active-high reset
//   tick_multiplex : in  multiplex step from the divider (edge-detected)
//   habilita       : in  1 = display on; 0 = anodes off, scan frozen
//   digitos        : in  BCD nibbles, nibble i drives digit i (0 = rightmost)
//   pontos         : in  decimal point request per digit
//   segmentos      : out {g,f,e,d,c,b,a} at board polarity
//   ponto          : out decimal point of the active digit
//   anodos         : out one-hot digit select at board polarity
module multiplexador_display
   import multiplexador_pkg::*;
#(
   parameter int unsigned N_DIGITOS   = 4,
   parameter bit          ATIVO_BAIXO = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   tick_multiplex,
   input  logic                   habilita,
   input  logic [4*N_DIGITOS-1:0] digitos,
   input  logic [N_DIGITOS-1:0]   pontos,
   output logic [SEG_LARGURA-1:0] segmentos,
   output logic                   ponto,
   output logic [N_DIGITOS-1:0]   anodos
);

   localparam int unsigned IW = $clog2(N_DIGITOS);
   localparam logic [IW-1:0] ULTIMO = IW'(N_DIGITOS - 1);

   // Physical "off" levels for the configured polarity.
   localparam logic [SEG_LARGURA-1:0] SEG_OFF = {SEG_LARGURA{ATIVO_BAIXO}};
   localparam logic [N_DIGITOS-1:0]   ANO_OFF = {N_DIGITOS{ATIVO_BAIXO}};

   estado_t                estado, estado_prox;
   logic [IW-1:0]          indice, indice_prox;
   logic [3:0]             buf_dig      [N_DIGITOS];
   logic [3:0]             buf_dig_prox [N_DIGITOS];
   logic [3:0]             captura      [N_DIGITOS];
   logic [N_DIGITOS-1:0]   buf_pto, buf_pto_prox;
   logic                   tick_prev;
   logic                   passo;
   logic [SEG_LARGURA-1:0] seg_prox;
   logic                   pto_prox;
   logic [N_DIGITOS-1:0]   ano_prox;
   logic [N_DIGITOS-1:0]   um_quente;
   logic [SEG_LARGURA-1:0] glifo_atual;

   assign passo = tick_multiplex & ~tick_prev;

   decodificador_7seg u_decod (
      .codigo (buf_dig[indice]),
      .glifo  (glifo_atual)
   );

   // Snapshot contents, with optional leading-zero blanking applied
   // from the most significant nibble downwards.
   always_comb begin
`ifdef SUPRIME_ZEROS_EN
      logic zeros_acima;
`endif
      for (int unsigned i = 0; i < N_DIGITOS; i++) begin
         captura[i] = digitos[4*i +: 4];
      end
`ifdef SUPRIME_ZEROS_EN
      zeros_acima = 1'b1;
      for (int unsigned k = 1; k < N_DIGITOS; k++) begin
         if (zeros_acima && (captura[N_DIGITOS-k] == 4'h0)) begin
            captura[N_DIGITOS-k] = COD_APAGADO;
         end else begin
            zeros_acima = 1'b0;
         end
      end
`endif
   end

   always_comb begin
      um_quente         = '0;
      um_quente[indice] = 1'b1;
   end

   // Next-state and output logic. Outputs hold by default; the anodes
   // are only driven while showing, so both the step cycle and the
   // disabled state present all anodes off.
   always_comb begin
      estado_prox  = estado;
      indice_prox  = indice;
      buf_dig_prox = buf_dig;
      buf_pto_prox = buf_pto;
      seg_prox     = segmentos;
      pto_prox     = ponto;
      ano_prox     = ANO_OFF;

      if (!habilita) begin
         estado_prox = (estado == E_OCIOSO) ? E_OCIOSO : E_PAUSA;
      end else if (passo) begin
         estado_prox = E_PASSO;
         if (indice == ULTIMO) begin
            indice_prox  = '0;
            buf_dig_prox = captura;
            buf_pto_prox = pontos;
         end else begin
            indice_prox = indice + 1'b1;
         end
      end else if (estado != E_OCIOSO) begin
         // Covers both the cycle after a step and the first cycle after
         // re-enable, so no tick is needed to bring the digit back.
         estado_prox = E_EXIBE;
         ano_prox    = ATIVO_BAIXO ? ~um_quente : um_quente;
         seg_prox    = ATIVO_BAIXO ? ~glifo_atual : glifo_atual;
         pto_prox    = buf_pto[indice] ^ ATIVO_BAIXO;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado    <= E_OCIOSO;
         indice    <= '0;
         buf_dig   <= '{default: '0};
         buf_pto   <= '0;
         tick_prev <= 1'b1;
         segmentos <= SEG_OFF;
         ponto     <= ATIVO_BAIXO;
         anodos    <= ANO_OFF;
      end else begin
         estado    <= estado_prox;
         indice    <= indice_prox;
         buf_dig   <= buf_dig_prox;
         buf_pto   <= buf_pto_prox;
         tick_prev <= tick_multiplex;
         segmentos <= seg_prox;
         ponto     <= pto_prox;
         anodos    <= ano_prox;
      end
   end

endmodule

// File: tb/tb_multiplexador_display.sv
// tb_multiplexador_display
//   Directed bench for multiplexador_display (N_DIGITOS = 4, ATIVO_BAIXO = 1).
//   Expected values are physical (active-low) levels.
module tb_multiplexador_display;

   logic        clk = 1'b0;
   logic        reset;
   logic        tick_multiplex;
   logic        habilita;
   logic [15:0] digitos;
   logic [3:0]  pontos;
   logic [6:0]  segmentos;
   logic        ponto;
   logic [3:0]  anodos;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   multiplexador_display #(
      .N_DIGITOS   (4),
      .ATIVO_BAIXO (1'b1)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .tick_multiplex (tick_multiplex),
      .habilita       (habilita),
      .digitos        (digitos),
      .pontos         (pontos),
      .segmentos      (segmentos),
      .ponto          (ponto),
      .anodos         (anodos)
   );

   // One tick pulse; returns at the negedge after the stepping edge.
   task automatic pulso();
      @(negedge clk) tick_multiplex = 1'b1;
      @(negedge clk) tick_multiplex = 1'b0;
   endtask

   // Step and let the new digit reach the outputs.
   task automatic avanca();
      pulso();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; tick_multiplex = 1'b1; habilita = 1'b1;
      digitos = 16'h0000; pontos = 4'b0000;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (anodos !== 4'hF) begin errors++; $display("FAIL reset_anodos got %h exp %h", anodos, 4'hF); end
      checks++; if (segmentos !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h exp %h", segmentos, 7'h7F); end
      checks++; if (ponto !== 1'b1) begin errors++; $display("FAIL reset_ponto got %b exp 1", ponto); end
      tick_multiplex = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (anodos !== 4'hF) begin errors++; $display("FAIL reset_tick_low_anodos got %h exp %h", anodos, 4'hF); end
   endtask

   task automatic test_scan();
      logic [3:0] exp_ano [5] = '{4'hD, 4'hB, 4'h7, 4'hE, 4'hD};
      logic [6:0] exp_seg [5] = '{7'h40, 7'h40, 7'h40, 7'h19, 7'h30};
      digitos = 16'h1234; pontos = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         pulso();
         checks++; if (anodos !== 4'hF) begin errors++; $display("FAIL scan_blank[%0d] got %h exp %h", i, anodos, 4'hF); end
         @(negedge clk);
         checks++; if (anodos !== exp_ano[i]) begin errors++; $display("FAIL scan_anodos[%0d] got %h exp %h", i, anodos, exp_ano[i]); end
         checks++; if (segmentos !== exp_seg[i]) begin errors++; $display("FAIL scan_seg[%0d] got %h exp %h", i, segmentos, exp_seg[i]); end
      end
      // Outputs hold between steps.
      repeat (3) @(negedge clk);
      checks++; if (segmentos !== 7'h30 || anodos !== 4'hD) begin errors++; $display("FAIL scan_hold got %h/%h exp 30/d", segmentos, anodos); end
   endtask

   task automatic test_mid_frame();
      logic [3:0] exp_ano [3] = '{4'hB, 4'h7, 4'hE};
      logic [6:0] exp_seg [3] = '{7'h24, 7'h79, 7'h10};
      digitos = 16'h9999;
      for (int i = 0; i < 3; i++) begin
         avanca();
         checks++; if (anodos !== exp_ano[i]) begin errors++; $display("FAIL mid_anodos[%0d] got %h exp %h", i, anodos, exp_ano[i]); end
         checks++; if (segmentos !== exp_seg[i]) begin errors++; $display("FAIL mid_seg[%0d] got %h exp %h", i, segmentos, exp_seg[i]); end
      end
   endtask

   task automatic test_glyphs();
      logic [6:0] exp_seg [4] = '{7'h12, 7'h40, 7'h3F, 7'h7F};
      logic       exp_pto [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      digitos = 16'hFA05; pontos = 4'b0010;
      repeat (4) avanca();
      for (int i = 0; i < 4; i++) begin
         if (i != 0) avanca();
         checks++; if (segmentos !== exp_seg[i]) begin errors++; $display("FAIL glyph_seg[%0d] got %h exp %h", i, segmentos, exp_seg[i]); end
         checks++; if (ponto !== exp_pto[i]) begin errors++; $display("FAIL glyph_ponto[%0d] got %b exp %b", i, ponto, exp_pto[i]); end
      end
   endtask

   task automatic test_enable();
      avanca();
      avanca();
      @(negedge clk);
      habilita = 1'b0; tick_multiplex = 1'b1;
      @(negedge clk);
      checks++; if (anodos !== 4'hF) begin errors++; $display("FAIL disable_anodos got %h exp %h", anodos, 4'hF); end
      tick_multiplex = 1'b0;
      @(negedge clk) tick_multiplex = 1'b1;
      @(negedge clk) tick_multiplex = 1'b0;
      @(negedge clk);
      checks++; if (anodos !== 4'hF) begin errors++; $display("FAIL disabled_hold got %h exp %h", anodos, 4'hF); end
      habilita = 1'b1;
      @(negedge clk);
      checks++; if (anodos !== 4'hD) begin errors++; $display("FAIL reenable_anodos got %h exp %h", anodos, 4'hD); end
      checks++; if (segmentos !== 7'h40) begin errors++; $display("FAIL reenable_seg got %h exp %h", segmentos, 7'h40); end
      checks++; if (ponto !== 1'b0) begin errors++; $display("FAIL reenable_ponto got %b exp 0", ponto); end
   endtask

   task automatic test_mid_reset();
      logic [6:0] exp_alto;
`ifdef SUPRIME_ZEROS_EN
      exp_alto = 7'h7F;
`else
      exp_alto = 7'h40;
`endif
      digitos = 16'h0070; pontos = 4'b0000;
      @(negedge clk) begin reset = 1'b1; tick_multiplex = 1'b1; end
      @(negedge clk) begin reset = 1'b0; tick_multiplex = 1'b0; end
      checks++; if (anodos !== 4'hF || segmentos !== 7'h7F || ponto !== 1'b1) begin
         errors++; $display("FAIL midreset_outputs got %h/%h/%b exp f/7f/1", anodos, segmentos, ponto); end
      repeat (2) @(negedge clk);
      checks++; if (anodos !== 4'hF) begin errors++; $display("FAIL midreset_idle got %h exp %h", anodos, 4'hF); end
      avanca();
      checks++; if (anodos !== 4'hD || segmentos !== 7'h40) begin
         errors++; $display("FAIL midreset_first got %h/%h exp d/40", anodos, segmentos); end
      avanca();
      avanca();
      avanca();
      checks++; if (anodos !== 4'hE || segmentos !== 7'h40) begin
         errors++; $display("FAIL zeros_dig0 got %h/%h exp e/40", anodos, segmentos); end
      avanca();
      checks++; if (segmentos !== 7'h78) begin errors++; $display("FAIL zeros_dig1 got %h exp %h", segmentos, 7'h78); end
      avanca();
      checks++; if (segmentos !== exp_alto) begin errors++; $display("FAIL zeros_dig2 got %h exp %h", segmentos, exp_alto); end
      avanca();
      checks++; if (segmentos !== exp_alto) begin errors++; $display("FAIL zeros_dig3 got %h exp %h", segmentos, exp_alto); end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_mid_frame();
      test_glyphs();
      test_enable();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
